// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM port arbiter slice.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int AW_DEF      = 21;
  localparam int DW          = 16;
  localparam int DSW         = 2;
  localparam int PRIO_CLIENT = 0;

  // Index width that still works for a 1-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_select.sv
// Grant picker: client 0 wins outright, clients 1..NCLIENT-1 rotate from rr_ptr_i.
module rr_select
  import sdram_arb_pkg::*;
#(
  parameter int NCLIENT = 3,
  parameter int GW      = idx_w(NCLIENT)
) (
  input  logic [NCLIENT-1:0] req_i,
  input  logic [GW-1:0]      rr_ptr_i,
  output logic [GW-1:0]      grant_o,
  output logic               valid_o
);

  always_comb begin
    logic [GW:0] idx;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    if (req_i[PRIO_CLIENT]) begin
      grant_o = GW'(PRIO_CLIENT);
      valid_o = 1'b1;
    end else begin
      for (int k = 0; k < NCLIENT - 1; k++) begin
        // Candidate ptr+k, folded back into 1..NCLIENT-1.
        idx = {1'b0, rr_ptr_i} + (GW+1)'(k);
        if (idx > (GW+1)'(NCLIENT - 1)) idx = idx - (GW+1)'(NCLIENT - 1);
        if (!valid_o && req_i[idx[GW-1:0]]) begin
          grant_o = idx[GW-1:0];
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multiplexes NCLIENT level-request clients onto one toggle req/ack SDRAM port.
//   state | meaning
//   DRAIN | post-reset wait, swallows any stale ack from an interrupted access
//   IDLE  | pick a client and launch its access
//   WAIT  | access in flight, port fields held
//   DONE  | one-cycle cli_ack with cli_q
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCLIENT      = 3,
  parameter int AW           = AW_DEF,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCLIENT-1:0]    cli_req,
  input  logic [NCLIENT-1:0]    cli_we,
  input  logic [NCLIENT*AW-1:0] cli_a,
  input  logic [NCLIENT*2-1:0]  cli_ds,
  input  logic [NCLIENT*16-1:0] cli_d,
  output logic [NCLIENT-1:0]    cli_ack,
  output logic [15:0]           cli_q,
  output logic                  port_req,
  input  logic                  port_ack,
  output logic                  port_we,
  output logic [AW-1:0]         port_a,
  output logic [1:0]            port_ds,
  output logic [15:0]           port_d,
  input  logic [15:0]           port_q
);

  localparam int GW = idx_w(NCLIENT);
  localparam int CW = idx_w(DRAIN_CYCLES);

  arb_state_e state_q, state_d;

  logic [CW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               port_req_q, port_req_d;
  logic               ack_q;
  logic               port_we_q, port_we_d;
  logic [AW-1:0]      port_a_q, port_a_d;
  logic [DSW-1:0]     port_ds_q, port_ds_d;
  logic [DW-1:0]      port_d_q, port_d_d;
  logic [NCLIENT-1:0] cli_ack_q, cli_ack_d;
  logic [DW-1:0]      cli_q_q, cli_q_d;

  logic [GW-1:0] rr_grant;
  logic          rr_valid;
  logic          drain_end;
  logic          acc_done;

  rr_select #(.NCLIENT(NCLIENT), .GW(GW)) u_rr_select (
    .req_i    (cli_req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (rr_grant),
    .valid_o  (rr_valid)
  );

  assign drain_end = (drain_cnt_q == CW'(DRAIN_CYCLES - 1));
  assign acc_done  = (ack_q == port_req_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= DRAIN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DRAIN: if (drain_end) state_d = IDLE;
      IDLE:  if (rr_valid)  state_d = WAIT;
      WAIT:  if (acc_done)  state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = DRAIN;
    endcase
  end

  always_comb begin
    drain_cnt_d = drain_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    port_req_d  = port_req_q;
    port_we_d   = port_we_q;
    port_a_d    = port_a_q;
    port_ds_d   = port_ds_q;
    port_d_d    = port_d_q;
    cli_q_d     = cli_q_q;
    cli_ack_d   = '0;
    unique case (state_q)
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + CW'(1);
        if (drain_end) port_req_d = port_ack;
      end
      IDLE: begin
        if (rr_valid) begin
          grant_d    = rr_grant;
          port_we_d  = cli_we[rr_grant];
          port_a_d   = cli_a[int'(rr_grant)*AW +: AW];
          port_ds_d  = cli_ds[int'(rr_grant)*DSW +: DSW];
          port_d_d   = cli_d[int'(rr_grant)*DW +: DW];
          port_req_d = ~port_req_q;
          if (rr_grant != GW'(PRIO_CLIENT))
            rr_ptr_d = (rr_grant == GW'(NCLIENT - 1)) ? GW'(1) : rr_grant + GW'(1);
        end
      end
      WAIT: begin
        if (acc_done) begin
          cli_q_d            = port_q;
          cli_ack_d[grant_q] = 1'b1;
        end
      end
      DONE: ;
      default: ;
    endcase
  end

  // port_req tracks port_ack throughout reset so the port never looks busy.
  always_ff @(posedge clk) begin
    ack_q <= port_ack;
    if (reset) begin
      drain_cnt_q <= '0;
      rr_ptr_q    <= GW'(1);
      grant_q     <= '0;
      port_req_q  <= port_ack;
      port_we_q   <= 1'b0;
      port_a_q    <= '0;
      port_ds_q   <= '0;
      port_d_q    <= '0;
      cli_ack_q   <= '0;
      cli_q_q     <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      port_req_q  <= port_req_d;
      port_we_q   <= port_we_d;
      port_a_q    <= port_a_d;
      port_ds_q   <= port_ds_d;
      port_d_q    <= port_d_d;
      cli_ack_q   <= cli_ack_d;
      cli_q_q     <= cli_q_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == WAIT) assert (port_req_d == port_req_q);
  end

  assign port_req = port_req_q;
  assign port_we  = port_we_q;
  assign port_a   = port_a_q;
  assign port_ds  = port_ds_q;
  assign port_d   = port_d_q;
  assign cli_ack  = cli_ack_q;
  assign cli_q    = cli_q_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: toggle-protocol controller model plus ack scoreboard.
module tb_sdram_port_arbiter;

  localparam int NC = 3;
  localparam int AW = 21;
  localparam int DRAIN = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] cli_req, cli_we, cli_ack;
  logic [NC*AW-1:0] cli_a;
  logic [NC*2-1:0]  cli_ds;
  logic [NC*16-1:0] cli_d;
  logic [15:0]   cli_q;
  logic          port_req, port_ack, port_we;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic [15:0]   port_d, port_q;

  sdram_port_arbiter #(.NCLIENT(NC), .AW(AW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset),
    .cli_req(cli_req), .cli_we(cli_we), .cli_a(cli_a), .cli_ds(cli_ds), .cli_d(cli_d),
    .cli_ack(cli_ack), .cli_q(cli_q),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .port_q(port_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          client;
    logic [15:0] q;
    bit          chk_q;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] rdata(input logic [AW-1:0] a);
    if (a == 21'h00100) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Controller model: latches a request on req!=ack, answers ctrl_lat clocks later with ack=req.
  int          ctrl_lat = 6;
  bit          busy = 1'b0;
  int          cnt;
  logic        lat_req, lat_we;
  logic [AW-1:0] lat_a;

  always @(negedge clk) begin
    if (busy) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        if (!lat_we) port_q = rdata(lat_a);
        port_ack = lat_req;
        busy = 1'b0;
      end
    end else if (!reset && port_req !== port_ack) begin
      busy    = 1'b1;
      cnt     = ctrl_lat;
      lat_req = port_req;
      lat_we  = port_we;
      lat_a   = port_a;
    end
  end

  task automatic set_client(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [1:0] ds, input logic [15:0] d);
    cli_we[i]          = we;
    cli_a[i*AW +: AW]  = a;
    cli_ds[i*2 +: 2]   = ds;
    cli_d[i*16 +: 16]  = d;
  endtask

  task automatic wait_ack(input string name, input bit rearm);
    int n;
    exp_t e;
    logic [NC-1:0] acked;
    n = 0;
    while (cli_ack === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cli_ack === '0) begin
      bad++;
      $display("FAIL %s: cli_ack got %b want a pulse within 200 cycles", name, cli_ack);
      return;
    end
    acked = cli_ack;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: cli_ack got %b want none (scoreboard empty)", name, acked);
    end else begin
      e = sb.pop_front();
      if (acked !== NC'(1 << e.client)) begin
        bad++;
        $display("FAIL %s: cli_ack got %b want %b", name, acked, NC'(1 << e.client));
      end
      if (e.chk_q) begin
        total++;
        if (cli_q !== e.q) begin
          bad++;
          $display("FAIL %s_q: cli_q got %h want %h", name, cli_q, e.q);
        end
      end
    end
    cli_req = cli_req & ~acked;
    @(negedge clk);
    total++;
    if (cli_ack !== '0) begin
      bad++;
      $display("FAIL %s_pulse: cli_ack got %b want 000 after one cycle", name, cli_ack);
    end
    if (rearm) cli_req = cli_req | acked;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (DRAIN + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (port_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_port_req: got %b want 1", port_req);
    end
    total++;
    if ({cli_ack, cli_q, port_we, port_a, port_ds, port_d} !== '0) begin
      bad++;
      $display("FAIL reset_values: ack=%b q=%h we=%b a=%h ds=%b d=%h want all 0",
               cli_ack, cli_q, port_we, port_a, port_ds, port_d);
    end
    set_client(1, 1'b0, 21'h00055, 2'b11, 16'h0);
    cli_req[1] = 1'b1;
    sb.push_back('{1, rdata(21'h00055), 1'b1});
    reset = 1'b0;
    for (int k = 1; k <= DRAIN; k++) begin
      @(negedge clk);
      total++;
      if (port_req !== 1'b1 || cli_ack !== '0) begin
        bad++;
        $display("FAIL drain_hold_%0d: port_req=%b cli_ack=%b want 1 / 000", k, port_req, cli_ack);
      end
    end
    @(negedge clk);
    total++;
    if (port_req !== 1'b0) begin
      bad++;
      $display("FAIL drain_exit_toggle: port_req got %b want 0", port_req);
    end
    wait_ack("reset_first_read", 1'b0);
  endtask

  task automatic test_single_read();
    logic prev;
    set_client(1, 1'b0, 21'h00100, 2'b11, 16'h0);
    prev = port_req;
    cli_req[1] = 1'b1;
    sb.push_back('{1, 16'hBEEF, 1'b1});
    @(negedge clk);
    total++;
    if (port_req !== ~prev) begin
      bad++;
      $display("FAIL read_toggle_latency: port_req got %b want %b", port_req, ~prev);
    end
    total++;
    if (port_a !== 21'h00100 || port_ds !== 2'b11 || port_we !== 1'b0) begin
      bad++;
      $display("FAIL read_port_fields: a=%h ds=%b we=%b want 000100/11/0", port_a, port_ds, port_we);
    end
    wait_ack("single_read", 1'b0);
  endtask

  task automatic test_priority();
    do_reset();
    set_client(0, 1'b0, 21'h00010, 2'b11, 16'h0);
    set_client(1, 1'b0, 21'h00011, 2'b11, 16'h0);
    set_client(2, 1'b0, 21'h00012, 2'b11, 16'h0);
    cli_req = 3'b111;
    sb.push_back('{0, rdata(21'h00010), 1'b1});
    sb.push_back('{1, rdata(21'h00011), 1'b1});
    sb.push_back('{2, rdata(21'h00012), 1'b1});
    wait_ack("prio_0", 1'b0);
    wait_ack("prio_1", 1'b0);
    wait_ack("prio_2", 1'b0);
  endtask

  task automatic test_rr_wrap();
    cli_req = 3'b110;
    sb.push_back('{1, rdata(21'h00011), 1'b1});
    sb.push_back('{2, rdata(21'h00012), 1'b1});
    sb.push_back('{1, rdata(21'h00011), 1'b1});
    sb.push_back('{2, rdata(21'h00012), 1'b1});
    wait_ack("rr_a", 1'b1);
    wait_ack("rr_b", 1'b1);
    wait_ack("rr_c", 1'b1);
    wait_ack("rr_d", 1'b0);
    cli_req = '0;
  endtask

  task automatic test_write();
    logic prev, cur;
    int n;
    set_client(2, 1'b1, 21'h1FFFFF, 2'b01, 16'h1234);
    prev = port_req;
    cli_req[2] = 1'b1;
    sb.push_back('{2, 16'h0, 1'b0});
    @(negedge clk);
    cur = port_req;
    total++;
    if (cur !== ~prev) begin
      bad++;
      $display("FAIL write_toggle: port_req got %b want %b", cur, ~prev);
    end
    n = 0;
    while (cli_ack === '0 && n < 100) begin
      total++;
      if (port_we !== 1'b1 || port_a !== 21'h1FFFFF || port_ds !== 2'b01 ||
          port_d !== 16'h1234 || port_req !== cur) begin
        bad++;
        $display("FAIL write_hold_%0d: we=%b a=%h ds=%b d=%h req=%b want 1/1fffff/01/1234/%b",
                 n, port_we, port_a, port_ds, port_d, port_req, cur);
      end
      @(negedge clk);
      n++;
    end
    wait_ack("write", 1'b0);
    set_client(2, 1'b0, 21'h00012, 2'b11, 16'h0);
  endtask

  task automatic test_reset_mid_wait();
    set_client(1, 1'b0, 21'h00200, 2'b11, 16'h0);
    cli_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cli_req = '0;
    for (int k = 0; k < DRAIN + 8; k++) begin
      @(negedge clk);
      total++;
      if (cli_ack !== '0) begin
        bad++;
        $display("FAIL abandon_no_ack_%0d: cli_ack got %b want 000", k, cli_ack);
      end
    end
    total++;
    if (port_req !== port_ack) begin
      bad++;
      $display("FAIL post_drain_idle: port_req=%b port_ack=%b want equal", port_req, port_ack);
    end
    set_client(2, 1'b0, 21'h00042, 2'b10, 16'h0);
    cli_req[2] = 1'b1;
    sb.push_back('{2, rdata(21'h00042), 1'b1});
    wait_ack("after_abandon", 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    cli_req  = '0;
    cli_we   = '0;
    cli_a    = '0;
    cli_ds   = '0;
    cli_d    = '0;
    port_ack = 1'b1;
    port_q   = 16'h0;
    test_reset();
    test_single_read();
    test_priority();
    test_rr_wrap();
    test_write();
    test_reset_mid_wait();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
